// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction-fetch stage of the five-stage RISC-V core.
//
// Builds each 32-bit instruction from four little-endian byte reads on a
// byte-wide memory port that is shared with the MEM stage (MEM has priority,
// so a read only goes out in a cycle where mem_grant_i is high).  While an
// instruction is being assembled the stage holds stallreq_if high so that
// IF/ID inserts a bubble.  An EX redirect takes effect on the next edge and
// throws away any partially fetched instruction.
//
// State | Meaning
// ------+-------------------------------------------------------------------
// FETCH | issuing byte reads pc..pc+3 and capturing the returned bytes;
//       | if_inst = 0, stallreq_if = 1
// DONE  | instruction presented on if_pc/if_inst, stallreq_if = 0; no reads;
//       | advances to pc+4 when stall[0] releases
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   stall[5:0]       pipeline stall vector from ctrl; only stall[0] is used
//   branch_flag_i    EX redirect qualifier (single cycle)
//   branch_target_i  redirect address
//   mem_grant_i      memory arbiter grant for this cycle
//   mem_din_i        read byte, valid the cycle after an issued read
//   mem_a_o          byte read address (pc + bytes already issued)
//   mem_rd_o         read strobe, combinational
//   if_pc            PC of the presented instruction (registered)
//   if_inst          presented instruction, zero while fetching (registered)
//   stallreq_if      stall request while no instruction is available
// ---------------------------------------------------------------------------
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_grant_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        STOP     = 1'b1;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        pend;
  logic [7:0]  b0, b1, b2;
  logic        want_issue;

  // Only the PC-hold bit of the stall vector matters to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  assign want_issue = (state == FETCH) && (issue_cnt < 3'd4);
  assign mem_a_o    = pc + {29'd0, issue_cnt};
  // Reset and redirect both suppress the read so no stray byte is requested
  // for an address that is about to be abandoned.
  assign mem_rd_o   = want_issue && mem_grant_i && !rst && !branch_flag_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= ZeroWord;
      issue_cnt   <= 3'd0;
      recv_cnt    <= 3'd0;
      pend        <= 1'b0;
      b0          <= 8'h00;
      b1          <= 8'h00;
      b2          <= 8'h00;
      if_pc       <= ZeroWord;
      if_inst     <= ZeroWord;
      stallreq_if <= 1'b0;
    end else if (branch_flag_i) begin
      // Redirect wins over everything, including a capture that would have
      // completed the instruction this cycle.
      state       <= FETCH;
      pc          <= branch_target_i;
      issue_cnt   <= 3'd0;
      recv_cnt    <= 3'd0;
      pend        <= 1'b0;
      if_inst     <= ZeroWord;
      stallreq_if <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if_inst     <= ZeroWord;
          stallreq_if <= 1'b1;

          if (mem_rd_o) begin
            issue_cnt <= issue_cnt + 3'd1;
            pend      <= 1'b1;
          end else begin
            pend      <= 1'b0;
          end

          if (pend) begin
            recv_cnt <= recv_cnt + 3'd1;
            case (recv_cnt)
              3'd0:    b0 <= mem_din_i;
              3'd1:    b1 <= mem_din_i;
              3'd2:    b2 <= mem_din_i;
              default: ;
            endcase
            // Fourth byte goes straight to the output; no need to buffer it.
            if (recv_cnt == 3'd3) begin
              state       <= DONE;
              if_inst     <= {mem_din_i, b2, b1, b0};
              if_pc       <= pc;
              stallreq_if <= 1'b0;
            end
          end
        end

        DONE: begin
          pend <= 1'b0;
          if (stall[0] != STOP) begin
            state       <= FETCH;
            pc          <= pc + 32'd4;
            issue_cnt   <= 3'd0;
            recv_cnt    <= 3'd0;
            if_inst     <= ZeroWord;
            stallreq_if <= 1'b1;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule
